// File: rtl/ag_ps2_pkg.sv
// Purpose : shared types and constants for the PS/2 keyboard receiver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ag_ps2_pkg;

    // Receiver frame-walk states: start bit seen -> 8 data -> parity -> stop.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Prefix bytes: never queued, they only tag the following scan code.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // One queued scan code with its prefix tags (10 bits).
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ag_ps2_rx_if.sv
// Purpose : scan-code handoff between the PS/2 receiver and the key register logic.
// Latency : n/a (wires only).
// Backpressure: consumer pops with code_ack while code_valid is high; entries wait otherwise.
//
// Signals: code/code_ext/code_brk/code_valid driven by the receiver (master),
//          code_ack driven by the consumer (slave).
interface ag_ps2_rx_if;
    logic [7:0] code;
    logic       code_ext;
    logic       code_brk;
    logic       code_valid;
    logic       code_ack;

    modport master (
        output code, code_ext, code_brk, code_valid,
        input  code_ack
    );

    modport slave (
        input  code, code_ext, code_brk, code_valid,
        output code_ack
    );
endinterface

// File: rtl/ag_ps2_fifo.sv
// Purpose : small synchronous FIFO holding decoded scan-code entries.
// Latency : a push is visible at the head on the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
//
// Ports: clk, rst_n; push/push_dat in; pop in (ignored when empty);
//        pop_dat = head entry; full/empty status.
module ag_ps2_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally: DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ag_ps2_rx.sv
// Purpose : PS/2 keyboard receiver: synchronise + deglitch pins, decode frames,
//           queue make/break codes tagged with E0/F0 prefix flags.
// Latency : code_valid rises the cycle after the filtered stop-bit falling edge.
// Backpressure: consumer pops with code_ack; a code arriving while full is dropped (overflow pulse).
//
// Ports: clk, rst_n (async active-low); ps2_clk/ps2_data raw async pins;
//        kbd (master): code, code_ext, code_brk, code_valid out, code_ack in;
//        err_parity/err_frame/overflow one-cycle pulses; busy = frame in progress.
module ag_ps2_rx
    import ag_ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ag_ps2_rx_if.master   kbd,
    output logic          err_parity,
    output logic          err_frame,
    output logic          overflow,
    output logic          busy
);
    localparam logic [3:0]  FL_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Synchroniser + counter filter, bit 0 = ps2_clk, bit 1 = ps2_data.
    // Lines reset to 1, the idle level of an open-collector PS/2 bus.
    // ------------------------------------------------------------------
    logic [1:0] raw_lines;
    logic [1:0] filt_lines;

    assign raw_lines = {ps2_data, ps2_clk};

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic       meta;
        logic       sync;
        logic       filt;
        logic [3:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta <= 1'b1;
                sync <= 1'b1;
                filt <= 1'b1;
                cnt  <= '0;
            end else begin
                meta <= raw_lines[g];
                sync <= meta;
                // Any sample agreeing with the filtered value restarts the run.
                if (sync != filt) begin
                    if (cnt == FL_LAST) begin
                        filt <= sync;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign filt_lines[g] = filt;
    end

    logic filt_clk;
    logic filt_dat;
    logic clk_prev;
    logic fall;

    assign filt_clk = filt_lines[0];
    assign filt_dat = filt_lines[1];
    assign fall     = clk_prev & ~filt_clk;

    // ------------------------------------------------------------------
    // Scan-code queue
    // ------------------------------------------------------------------
    ps2_entry_t push_dat;
    ps2_entry_t head;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic [15:0] to_cnt;
    logic       ext_flag;
    logic       brk_flag;

    logic stop_fall;
    logic is_prefix;

    assign stop_fall = fall && (state == ST_STOP);
    assign is_prefix = (shreg == PS2_EXT) || (shreg == PS2_BRK);
    // Push straight from the decode cycle so the entry is at the head one cycle later.
    assign push      = stop_fall && filt_dat && odd_parity_ok(shreg, par_bit) && !is_prefix;
    assign pop       = kbd.code_ack && !fifo_empty;
    assign push_dat  = '{ext: ext_flag, brk: brk_flag, code: shreg};

    ag_ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (10)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head is masked while empty so stale storage never reaches the outputs.
    assign kbd.code       = fifo_empty ? 8'h00 : head.code;
    assign kbd.code_ext   = fifo_empty ? 1'b0  : head.ext;
    assign kbd.code_brk   = fifo_empty ? 1'b0  : head.brk;
    assign kbd.code_valid = ~fifo_empty;

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Frame FSM
    // to_cnt holds the number of cycles since the last fall, so the abort
    // pulse appears exactly TIMEOUT cycles after that fall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev   <= 1'b1;
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            clk_prev   <= filt_clk;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            overflow   <= 1'b0;

            if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
                // Stalled frame: drop whatever was shifted in.
                err_frame <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
                state     <= ST_IDLE;
            end else begin
                if (fall)
                    to_cnt <= 16'd1;
                else if (state != ST_IDLE)
                    to_cnt <= to_cnt + 16'd1;

                case (state)
                    ST_IDLE: begin
                        if (fall) begin
                            if (!filt_dat) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                            end else begin
                                err_frame <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (fall) begin
                            // LSB first: each new bit enters at the top.
                            shreg <= {filt_dat, shreg[7:1]};
                            if (bit_cnt == 3'd7)
                                state <= ST_PARITY;
                            else
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (fall) begin
                            par_bit <= filt_dat;
                            state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (fall) begin
                            state <= ST_IDLE;
                            if (!filt_dat) begin
                                err_frame <= 1'b1;
                                ext_flag  <= 1'b0;
                                brk_flag  <= 1'b0;
                            end else if (!odd_parity_ok(shreg, par_bit)) begin
                                err_parity <= 1'b1;
                                ext_flag   <= 1'b0;
                                brk_flag   <= 1'b0;
                            end else if (shreg == PS2_EXT) begin
                                ext_flag <= 1'b1;
                            end else if (shreg == PS2_BRK) begin
                                brk_flag <= 1'b1;
                            end else begin
                                ext_flag <= 1'b0;
                                brk_flag <= 1'b0;
                                if (fifo_full && !pop) overflow <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ag_ps2_rx.sv
// Purpose : directed self-checking bench for ag_ps2_rx.
// Latency : pin fall to decode cycle is FILTER_LEN+2 cycles; code_valid one cycle later.
// Backpressure: bench pops entries with one-cycle code_ack pulses.
module tb_ag_ps2_rx;
    localparam int FL    = 4;
    localparam int TO    = 2000;
    localparam int DEPTH = 4;
    localparam int H     = 20;   // PS/2 clock half period in clk cycles

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic err_parity;
    logic err_frame;
    logic overflow;
    logic busy;

    ag_ps2_rx_if kbd();

    ag_ps2_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kbd        (kbd),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   n_ep      = 0;
    int   n_ef      = 0;
    int   n_ov      = 0;
    int   ef_cyc    = -1;
    int   vld_rise  = -1;
    int   last_fall = 0;
    logic ef_busy   = 1'b1;
    logic vld_q     = 1'b0;

    always @(posedge clk) cyc++;

    // Pulse counters count high cycles, so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (err_parity) n_ep++;
        if (err_frame) begin
            n_ef++;
            ef_cyc  = cyc;
            ef_busy = busy;
        end
        if (overflow) n_ov++;
        if (kbd.code_valid && !vld_q) vld_rise = cyc;
        vld_q = kbd.code_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set mid-high, clock low H cycles, clock high again.
    task automatic fall_bit(input logic b, input bit glitch, input bit ack_here);
        ps2_data = b;
        idle(H/2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        for (int i = 0; i < H; i++) begin
            kbd.code_ack = (ack_here && i == FL + 2);
            @(negedge clk);
        end
        kbd.code_ack = 1'b0;
        ps2_clk = 1'b1;
        if (glitch) begin
            idle(7);
            ps2_clk = 1'b0;
            idle(FL - 1);
            ps2_clk = 1'b1;
            idle(H/2 - 7 - (FL - 1));
        end else begin
            idle(H/2);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int nfalls, input bit glitch, input bit ack_stop);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfalls; i++)
            fall_bit(bits[i], glitch && i == 4, ack_stop && i == 10);
        ps2_data = 1'b1;
        idle(H);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    endtask

    // Check head entry {ext,brk,code} with valid set, then pop it.
    task automatic pop_chk(input string tag, input logic [9:0] exp);
        chk(tag, {kbd.code_valid, kbd.code_ext, kbd.code_brk, kbd.code}, {1'b1, exp});
        kbd.code_ack = 1'b1;
        @(negedge clk);
        kbd.code_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ep0, ef0, ov0;
        kbd.code_ack = 1'b0;
        idle(3);
        chk("rst_outs", {kbd.code_valid, kbd.code_ext, kbd.code_brk, kbd.code,
                         err_parity, err_frame, overflow, busy}, 0);
        rst_n = 1'b1;
        idle(5);

        // 1: single make code, latency, ack
        vld_rise = -1;
        send(8'h1C);
        chk("t1_latency", vld_rise, last_fall + FL + 3);
        pop_chk("t1_code", {2'b00, 8'h1C});
        chk("t1_empty", kbd.code_valid, 0);

        // 2: prefixes fold into one entry
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_chk("t2_brk", {2'b01, 8'h1C});
        pop_chk("t2_ext_brk", {2'b11, 8'h75});
        chk("t2_empty", kbd.code_valid, 0);

        // 3: parity errors, prefix flags cleared by an error
        ep0 = n_ep;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        chk("t3_perr", n_ep - ep0, 1);
        chk("t3_empty", kbd.code_valid, 0);
        send(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        send(8'h1C);
        chk("t3_perr2", n_ep - ep0, 2);
        pop_chk("t3_brk_cleared", {2'b00, 8'h1C});

        // bad stop bit
        ef0 = n_ef;
        send_frame(8'h2A, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        chk("stop_ferr", n_ef - ef0, 1);
        chk("stop_empty", kbd.code_valid, 0);

        // 4: overflow, then push+pop at full
        ov0 = n_ov;
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("t4_ovf", n_ov - ov0, 1);
        chk("t4_head", {kbd.code_valid, kbd.code_ext, kbd.code_brk, kbd.code}, {1'b1, 2'b00, 8'h01});
        send_frame(8'h06, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        chk("t4_no_ovf", n_ov - ov0, 1);
        pop_chk("t4_q0", {2'b00, 8'h02});
        pop_chk("t4_q1", {2'b00, 8'h03});
        pop_chk("t4_q2", {2'b00, 8'h04});
        pop_chk("t4_q3", {2'b00, 8'h06});
        chk("t4_empty", kbd.code_valid, 0);

        // 5: timeout after 4 data bits
        ef0 = n_ef;
        ef_cyc = -1;
        send_frame(8'h33, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        chk("t5_busy", busy, 1);
        for (int i = 0; i < TO + 100 && n_ef == ef0; i++) @(negedge clk);
        chk("t5_ferr_time", ef_cyc, last_fall + FL + 2 + TO);
        chk("t5_busy_at_err", ef_busy, 0);
        idle(5);
        chk("t5_one_pulse", n_ef - ef0, 1);
        chk("t5_empty", kbd.code_valid, 0);
        send(8'h5A);
        pop_chk("t5_after", {2'b00, 8'h5A});

        // 6: short glitches are ignored
        ef0 = n_ef;
        ps2_data = 1'b0;
        idle(5);
        ps2_clk = 1'b0;
        idle(FL - 1);
        ps2_clk = 1'b1;
        idle(12);
        chk("t6_idle_glitch_busy", busy, 0);
        ps2_data = 1'b1;
        idle(12);
        chk("t6_idle_glitch_ferr", n_ef - ef0, 0);
        send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b1, 1'b0);
        pop_chk("t6_glitch_frame", {2'b00, 8'h4B});

        // reset mid-frame with an entry queued
        send(8'h12);
        send_frame(8'h34, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        ep0 = n_ep; ef0 = n_ef; ov0 = n_ov;
        rst_n = 1'b0;
        idle(2);
        chk("rst_mid_outs", {kbd.code_valid, kbd.code_ext, kbd.code_brk, kbd.code,
                             err_parity, err_frame, overflow, busy}, 0);
        idle(3);
        rst_n = 1'b1;
        idle(12);
        chk("rst_mid_no_pulse", (n_ep - ep0) + (n_ef - ef0) + (n_ov - ov0), 0);
        chk("rst_mid_flushed", kbd.code_valid, 0);
        send(8'h66);
        pop_chk("rst_after", {2'b00, 8'h66});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
